piso_tx_ctrl: RTL and testbench
===============================

# piso_tx_ctrl

Sequencing controller for the team's MSB-first parallel-in/serial-out shift register. It accepts a parallel word from an upstream producer over a valid/ready handshake and captures it locally. It then drives the register's enable, load and shift strobes so that each bit stays on the serial line for a programmable number of clock cycles. It reports frame activity and completion to the surrounding transmitter logic.

## Interface
Reset is synchronous and active-high.

Parameters:
- DW, 10, word width; must equal the width of the attached shift register; DW >= 2
- BAUD_DIV, 4, clock cycles per serial bit; BAUD_DIV >= 1

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- enb  input  1  global enable; when low, all state freezes
- in_valid  input  1  upstream word valid
- in_data  input  DW  upstream word
- in_ready  output  1  controller can accept a word
- piso_data  output  DW  registered word, wired to the shift register's parallel input
- piso_enb  output  1  shift register enable
- piso_load  output  1  shift register load strobe
- piso_shift  output  1  shift register shift strobe
- bit_valid  output  1  serial line currently carries a frame bit
- busy  output  1  frame in progress (any state other than IDLE)
- done  output  1  one-cycle pulse after the last bit period

## Operation
- States: IDLE, LOAD, SHIFT, DONE. Internal counters:
  - div_cnt, counting 0..BAUD_DIV-1
  - bit_cnt, counting 0..DW-1
- IDLE:
  - in_ready = enb.
  - On handshake (in_valid && in_ready at an edge): piso_data <= in_data, then go to LOAD.
  - Otherwise hold.
- LOAD:
  - Lasts exactly 1 cycle, with piso_enb = 1 and piso_load = 1.
  - Clears div_cnt and bit_cnt, then goes to SHIFT.
- SHIFT:
  - piso_enb = 1 and bit_valid = 1 throughout. div_cnt increments each cycle.
  - When div_cnt == BAUD_DIV-1 and bit_cnt < DW-1: piso_shift = 1, div_cnt <= 0, bit_cnt increments.
  - When div_cnt == BAUD_DIV-1 and bit_cnt == DW-1: no shift; go to DONE.
  - Exactly DW-1 shift pulses are issued per frame.
- DONE: lasts 1 cycle with done = 1, then returns to IDLE.
- in_ready is 0 in LOAD, SHIFT and DONE. in_valid is ignored there; upstream must keep it asserted until accepted.
- piso_load and piso_shift are never asserted in the same cycle. Both are 0 whenever piso_enb is 0.
- enb low:
  - state, counters and piso_data hold.
  - piso_enb, piso_load, piso_shift, in_ready, done and bit_valid are all forced to 0.
  - busy still reflects the held state.
  - When enb rises, operation resumes exactly where it stopped; the bit period is stretched by the frozen cycles.
- All strobe and status outputs are registered or decoded from registered state only; there are no combinational paths from in_valid to any output.

## Timing
- Reset values: state IDLE, div_cnt 0, bit_cnt 0, piso_data all ones. All 1-bit outputs are 0 except in_ready, which equals enb.
- A reset asserted mid-frame returns to IDLE on the next edge. No done pulse is issued and the partial frame is discarded.
- Cycle numbering below assumes enb = 1 and counts from the handshake edge, which is cycle 0.
  - Cycle 1: LOAD. The shift register captures the word at the end of this cycle.
  - Bit k (k = 0 is the MSB) is on the serial output during cycles 2+k·BAUD_DIV through 1+(k+1)·BAUD_DIV.
  - piso_shift is high in the last cycle of bits 0..DW-2.
  - Cycle 2+DW·BAUD_DIV: DONE, with done = 1.
  - Cycle 3+DW·BAUD_DIV: IDLE, with in_ready = 1. This is the earliest edge at which the next handshake can occur.
- Throughput: one word per DW·BAUD_DIV + 3 cycles.
- With BAUD_DIV = 1, piso_shift is high in every SHIFT cycle except the last.

## Test plan
- Reset/idle (DW=10, BAUD_DIV=4): hold reset 3 cycles -> piso_data = 0x3FF, all strobes 0, in_ready = 1 after release.
- Single frame, in_data = 0x2A5 -> piso_load in cycle 1; 9 piso_shift pulses at cycles 5, 9, ..., 37; done in cycle 42; the serial output from an attached PISO reads 1,0,1,0,1,0,0,1,0,1, with each bit held 4 cycles.
- Back-to-back frames, in_valid held high with 0x3FF then 0x001 -> second handshake at cycle 43; no gap other than DONE and IDLE; both words serialized correctly.
- Enable pause: enb low for 5 cycles during bit 3 -> all strobes 0 during the pause; bit 3 lasts 9 cycles; done arrives 5 cycles later than nominal.
- Mid-frame reset at cycle 20 -> IDLE next cycle, no done pulse, piso_data = 0x3FF, and a new frame is accepted normally afterwards.
- BAUD_DIV=1, DW=4, in_data = 0xA -> load at cycle 1; shifts at cycles 2, 3, 4; done at cycle 6.

Source files
------------

// File: rtl/piso_tx_ctrl.sv
// Sequencing controller for an MSB-first PISO shift register.
// Captures a word over valid/ready and paces load/shift strobes per bit period.
module piso_tx_ctrl #(
    parameter int DW       = 10,
    parameter int BAUD_DIV = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enb,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic [DW-1:0] piso_data,
    output logic          piso_enb,
    output logic          piso_load,
    output logic          piso_shift,
    output logic          bit_valid,
    output logic          busy,
    output logic          done
);

    localparam int DIV_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int BIT_W = $clog2(DW);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BAUD_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DW - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic             div_end;
    logic             last_bit;

    assign div_end  = (div_cnt == DIV_LAST);
    assign last_bit = (bit_cnt == BIT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            piso_data <= '1;
        end else if (enb) begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        piso_data <= in_data;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    div_cnt <= '0;
                    bit_cnt <= '0;
                    state   <= SHIFT;
                end
                SHIFT: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        if (last_bit) state <= DONE;
                        else          bit_cnt <= bit_cnt + 1'b1;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                DONE: state <= IDLE;
            endcase
        end
    end

    // Strobes decode registered state only; enb gates them so a pause freezes cleanly.
    assign in_ready   = enb && (state == IDLE);
    assign piso_enb   = enb && ((state == LOAD) || (state == SHIFT));
    assign piso_load  = enb && (state == LOAD);
    assign piso_shift = enb && (state == SHIFT) && div_end && !last_bit;
    assign bit_valid  = enb && (state == SHIFT);
    assign busy       = (state != IDLE);
    assign done       = enb && (state == DONE);

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// Directed bench for piso_tx_ctrl: DW=10/BAUD_DIV=4 and DW=4/BAUD_DIV=1.
// Attached PISO models check the serial bit stream.
module tb_piso_tx_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       enb0, in_valid0, in_ready0;
    logic [9:0] in_data0, piso_data0;
    logic       piso_enb0, piso_load0, piso_shift0;
    logic       bit_valid0, busy0, done0;

    logic       enb1, in_valid1, in_ready1;
    logic [3:0] in_data1, piso_data1;
    logic       piso_enb1, piso_load1, piso_shift1;
    logic       bit_valid1, busy1, done1;

    logic [9:0] sr0;
    logic [3:0] sr1;

    int vec = 0;
    int err = 0;

    piso_tx_ctrl #(.DW(10), .BAUD_DIV(4)) u_dut0 (
        .clk(clk), .reset(reset), .enb(enb0),
        .in_valid(in_valid0), .in_data(in_data0), .in_ready(in_ready0),
        .piso_data(piso_data0), .piso_enb(piso_enb0),
        .piso_load(piso_load0), .piso_shift(piso_shift0),
        .bit_valid(bit_valid0), .busy(busy0), .done(done0)
    );

    piso_tx_ctrl #(.DW(4), .BAUD_DIV(1)) u_dut1 (
        .clk(clk), .reset(reset), .enb(enb1),
        .in_valid(in_valid1), .in_data(in_data1), .in_ready(in_ready1),
        .piso_data(piso_data1), .piso_enb(piso_enb1),
        .piso_load(piso_load1), .piso_shift(piso_shift1),
        .bit_valid(bit_valid1), .busy(busy1), .done(done1)
    );

    always_ff @(posedge clk) begin
        if (piso_enb0) begin
            if (piso_load0)       sr0 <= piso_data0;
            else if (piso_shift0) sr0 <= {sr0[8:0], 1'b0};
        end
        if (piso_enb1) begin
            if (piso_load1)       sr1 <= piso_data1;
            else if (piso_shift1) sr1 <= {sr1[2:0], 1'b0};
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vec++;
        if (got !== exp) begin
            err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One DW=10 frame from its handshake cycle; optional pause and reset cycle.
    task automatic frame0(input logic [9:0] w, input logic nv,
                          input logic [9:0] nd, input int ps,
                          input int pl, input int rc);
        int  t;
        bit  paused;
        bit  stop;
        stop      = 1'b0;
        in_valid0 = 1'b1;
        in_data0  = w;
        for (int n = 0; n <= 42 + pl && !stop; n++) begin
            paused = (pl > 0) && (n >= ps) && (n < ps + pl);
            enb0   = !paused;
            t      = (pl > 0 && n >= ps + pl) ? n - pl : n;
            #1;
            if (paused) begin
                chk("pause_strobes",
                    {26'd0, piso_enb0, piso_load0, piso_shift0,
                     bit_valid0, done0, in_ready0}, 32'd0);
                chk("pause_busy", 32'(busy0), 32'd1);
            end else begin
                chk("in_ready",   32'(in_ready0),   32'(t == 0));
                chk("piso_load",  32'(piso_load0),  32'(t == 1));
                chk("piso_enb",   32'(piso_enb0),   32'(t >= 1 && t <= 41));
                chk("piso_shift", 32'(piso_shift0),
                    32'(t >= 2 && t <= 37 && ((t - 2) % 4) == 3));
                chk("bit_valid",  32'(bit_valid0),  32'(t >= 2 && t <= 41));
                chk("done",       32'(done0),       32'(t == 42));
                chk("busy",       32'(busy0),       32'(t >= 1 && t <= 42));
                if (t >= 1)
                    chk("piso_data", 32'(piso_data0), 32'(w));
                if (t >= 2 && t <= 41)
                    chk("serial", 32'(sr0[9]), 32'(w[9 - (t - 2) / 4]));
            end
            if (n == rc) begin
                reset = 1'b1;
                stop  = 1'b1;
            end
            step();
            reset = 1'b0;
            if (n == 0) begin
                in_valid0 = nv;
                in_data0  = nd;
            end
        end
    endtask

    task automatic frame1(input logic [3:0] w);
        in_valid1 = 1'b1;
        in_data1  = w;
        for (int n = 0; n <= 6; n++) begin
            chk("d1_in_ready",   32'(in_ready1),   32'(n == 0));
            chk("d1_piso_load",  32'(piso_load1),  32'(n == 1));
            chk("d1_piso_shift", 32'(piso_shift1), 32'(n >= 2 && n <= 4));
            chk("d1_bit_valid",  32'(bit_valid1),  32'(n >= 2 && n <= 5));
            chk("d1_done",       32'(done1),       32'(n == 6));
            if (n >= 2 && n <= 5)
                chk("d1_serial", 32'(sr1[3]), 32'(w[3 - (n - 2)]));
            step();
            if (n == 0) in_valid1 = 1'b0;
        end
        chk("d1_ready_after", 32'(in_ready1), 32'd1);
        chk("d1_busy_after",  32'(busy1),     32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        enb0      = 1'b1;
        enb1      = 1'b1;
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
        in_data0  = '0;
        in_data1  = '0;
        repeat (3) step();
        chk("rst_piso_data", 32'(piso_data0), 32'h3FF);
        chk("rst_strobes",
            {27'd0, piso_enb0, piso_load0, piso_shift0, bit_valid0, done0},
            32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        reset = 1'b0;
        #1;
        chk("rel_in_ready",  32'(in_ready0),  32'd1);
        chk("rel_piso_data", 32'(piso_data0), 32'h3FF);
        enb0 = 1'b0;
        #1;
        chk("idle_ready_enb_low", 32'(in_ready0), 32'd0);
        enb0 = 1'b1;
        step();

        frame0(10'h2A5, 1'b0, 10'h000, -1, 0, -1);
        frame0(10'h3FF, 1'b1, 10'h001, -1, 0, -1);
        frame0(10'h001, 1'b0, 10'h000, -1, 0, -1);
        frame0(10'h1C3, 1'b0, 10'h000, 15, 5, -1);

        frame0(10'h155, 1'b0, 10'h000, -1, 0, 20);
        chk("mrst_busy",      32'(busy0),      32'd0);
        chk("mrst_piso_data", 32'(piso_data0), 32'h3FF);
        chk("mrst_in_ready",  32'(in_ready0),  32'd1);
        for (int i = 0; i < 30; i++) begin
            if (done0 !== 1'b0 || busy0 !== 1'b0)
                chk("mrst_quiet", {30'd0, done0, busy0}, 32'd0);
            step();
        end
        frame0(10'h0F0, 1'b0, 10'h000, -1, 0, -1);

        frame1(4'hA);

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
